ram_sp_clr: RTL and testbench
=============================

Name: ram_sp_clr

Overview:
- Parametrised single-port synchronous RAM; next generation of the fixed 1024x8 buffer RAM in the VLC TX/RX datapath.
- Generalised in data width and depth.
- Adds:
  - selectable read-during-write mode
  - optional output register stage
  - read-valid strobe
  - hardware clear sequencer that fills the array with a constant after reset or on request.
- Sits between framing logic and the modulator/demodulator as packet/symbol storage.

Parameters:
DATA_W, 8, data word width in bits
ADDR_W, 10, address width; depth DEPTH = 2**ADDR_W words
WR_MODE, 0, read-during-write: 0 = no-change, 1 = write-first, 2 = read-first
OUT_REG, 0, 0 = read latency 1 cycle; 1 = extra output register, latency 2 cycles
CLR_ON_RST, 1, 1 = clear sequence starts automatically out of reset
CLR_VAL, 0, DATA_W-bit value written to every word during clear

Ports:
clk  input  1  clock, all logic on rising edge
rst_n  input  1  synchronous active-low reset
clr_req  input  1  request full-array clear (sampled in IDLE only)
busy  output  1  high while the clear sequence owns the array
en  input  1  access enable
we  input  1  write enable, qualified by en
addr  input  ADDR_W  word address
din  input  DATA_W  write data
dout  output  DATA_W  read data
dout_vld  output  1  one-cycle strobe: dout updated this cycle

Behaviour:
- Reset (rst_n low at a clk edge):
  - dout=0, dout_vld=0, output pipeline cleared.
  - Clear address counter=0.
  - State = CLEAR if CLR_ON_RST=1, else IDLE; busy = CLR_ON_RST.
  - Array contents are not reset directly.
- FSM states:
  - IDLE: busy=0. User accesses accepted. clr_req=1 -> CLEAR next cycle.
  - CLEAR: busy=1.
    - Each cycle writes CLR_VAL to array[clr_addr], then clr_addr += 1.
    - The cycle writing DEPTH-1 is the last one; next state IDLE, clr_addr returns to 0.
    - busy is high for exactly DEPTH cycles.
    - clr_req ignored in CLEAR; no restart, no extension.
- User access, IDLE only:
  - en=1, we=0: read array[addr].
    - OUT_REG=0: dout and dout_vld=1 in cycle N+1.
    - OUT_REG=1: in cycle N+2.
  - en=1, we=1: array[addr] <= din. Output depends on WR_MODE:
    - WR_MODE=0: dout holds, dout_vld=0 (gen-1 behaviour).
    - WR_MODE=1: dout = din, dout_vld=1.
    - WR_MODE=2: dout = previous array[addr], dout_vld=1.
    - Latency for modes 1 and 2 is the same as a read.
  - en=0: no access, dout holds, dout_vld=0.
- Busy handling:
  - While busy=1, en/we/addr/din are ignored completely: no write, no new read, no dout_vld from new requests.
  - Reads issued before CLEAR began still complete through the pipeline with their pre-clear data.
- Simultaneous clr_req and en in IDLE: the user access is performed that cycle (any read returns pre-clear data); CLEAR begins next cycle.
- Back-to-back accesses: one per cycle, fully pipelined. dout_vld may stay high continuously.
- Reset mid-clear:
  - CLR_ON_RST=1: clear restarts from address 0.
  - CLR_ON_RST=0: returns to IDLE; array is partially cleared and this is legal.
  - Reset mid-read: in-flight dout_vld is dropped.
- Address wrap: clr_addr is ADDR_W bits and wraps to 0 naturally after DEPTH-1.
- dout retains its last value whenever dout_vld=0.

Test Plan:
- Reset with CLR_ON_RST=1, ADDR_W=10 -> busy=1 for exactly 1024 cycles after rst_n rises. Then reading addr 0, 513 and 1023 returns 0x00 with dout_vld one cycle after issue.
- IDLE, write 0xA5 @ 0x010 then read 0x010 (OUT_REG=0) -> dout=0xA5, dout_vld=1 at issue+1. With OUT_REG=1 -> at issue+2, and dout_vld=0 at issue+1.
- Write 0x3C @ 0x020, then write 0x77 @ 0x020 under each WR_MODE:
  - mode 0: dout unchanged, dout_vld=0.
  - mode 1: dout=0x77.
  - mode 2: dout=0x3C.
  - In every mode a subsequent read returns 0x77.
- CLR_VAL=0xFF: in one IDLE cycle assert clr_req with a read of a word holding 0x12 -> dout=0x12 delivered. busy rises the next cycle. A write of 0x55 during busy is dropped; after busy falls, that word reads 0xFF.
- Assert clr_req again mid-clear -> busy length unchanged (DEPTH cycles total).
- Pull rst_n low for 1 cycle at clear address 300 -> busy continuous, clear restarts at 0, busy deasserts 1024 cycles after rst_n returns high.
- Continuous reads of addresses 0..15 (OUT_REG=1) -> dout_vld high 16 consecutive cycles starting at issue+2, with data in address order.

Source files
------------

// File: rtl/ram_sp_clr.sv
// ram_sp_clr: parametrised single-port synchronous RAM with a selectable
// read-during-write mode, an optional output register, a read-valid strobe
// and a clear sequencer that fills the array with CLR_VAL.
module ram_sp_clr #(
   parameter int                 DATA_W     = 8,
   parameter int                 ADDR_W     = 10,
   parameter int                 WR_MODE    = 0,
   parameter int                 OUT_REG    = 0,
   parameter int                 CLR_ON_RST = 1,
   parameter logic [DATA_W-1:0]  CLR_VAL    = '0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clr_req,
   output logic              busy,
   input  logic              en,
   input  logic              we,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] din,
   output logic [DATA_W-1:0] dout,
   output logic              dout_vld
);

   localparam int DEPTH = 2 ** ADDR_W;

   typedef enum logic {
      IDLE  = 1'b0,
      CLEAR = 1'b1
   } state_t;

   state_t              state;
   state_t              state_nxt;
   logic [ADDR_W-1:0]   clr_addr;
   logic [DATA_W-1:0]   mem [DEPTH];
   logic                acc;
   logic                clr_wr;
   logic [DATA_W-1:0]   s1_data;
   logic                s1_vld;

   // User accesses only count in IDLE and outside reset; clear writes own the port otherwise.
   assign acc    = rst_n && (state == IDLE) && en;
   assign clr_wr = rst_n && (state == CLEAR);

   // State register and clear address counter (counter wraps to 0 after DEPTH-1).
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= (CLR_ON_RST != 0) ? CLEAR : IDLE;
         clr_addr <= '0;
      end else begin
         state <= state_nxt;
         if (state == CLEAR) begin
            clr_addr <= clr_addr + 1'b1;
         end
      end
   end

   // Next-state logic: clr_req is only honoured in IDLE; CLEAR always runs DEPTH cycles.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (clr_req) state_nxt = CLEAR;
         CLEAR:   if (clr_addr == '1) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // FSM outputs.
   always_comb begin
      busy = (state == CLEAR);
   end

   // Array write port, shared between the clear sequencer and user writes; no reset on contents.
   always_ff @(posedge clk) begin
      if (clr_wr) begin
         mem[clr_addr] <= CLR_VAL;
      end else if (acc && we) begin
         mem[addr] <= din;
      end
   end

   // First read stage: array read plus read-during-write selection.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s1_data <= '0;
         s1_vld  <= 1'b0;
      end else begin
         s1_vld <= 1'b0;
         if (acc) begin
            if (!we) begin
               s1_data <= mem[addr];
               s1_vld  <= 1'b1;
            end else if (WR_MODE == 1) begin
               s1_data <= din;
               s1_vld  <= 1'b1;
            end else if (WR_MODE == 2) begin
               s1_data <= mem[addr];
               s1_vld  <= 1'b1;
            end
         end
      end
   end

   generate
      if (OUT_REG != 0) begin : g_oreg
         logic [DATA_W-1:0] q_data;
         logic              q_vld;

         // Optional second stage; data only moves with a valid so dout holds otherwise.
         always_ff @(posedge clk) begin
            if (!rst_n) begin
               q_data <= '0;
               q_vld  <= 1'b0;
            end else begin
               q_vld <= s1_vld;
               if (s1_vld) begin
                  q_data <= s1_data;
               end
            end
         end

         assign dout     = q_data;
         assign dout_vld = q_vld;
      end else begin : g_noreg
         assign dout     = s1_data;
         assign dout_vld = s1_vld;
      end
   endgenerate

endmodule

// File: tb/tb_ram_sp_clr.sv
// tb_ram_sp_clr: directed bench for ram_sp_clr. Five instances share one
// stimulus stream and cover the write modes, output register and clear options.
module tb_ram_sp_clr;

   logic       clk;
   logic       rst_n;
   logic       clr_req;
   logic       en;
   logic       we;
   logic [9:0] addr;
   logic [7:0] din;
   logic [4:0] busy;
   logic [4:0] vld;
   logic [7:0] dout [5];

   int n_tests;
   int n_fail;
   int cnt;
   int lowcnt;

   // u0: mode 0, 1-cycle; u1: write-first; u2: read-first, clear to FF;
   // u3: mode 0 with output register; u4: no clear out of reset.
   ram_sp_clr #(.DATA_W(8), .ADDR_W(10), .WR_MODE(0), .OUT_REG(0), .CLR_ON_RST(1), .CLR_VAL(8'h00)) u0 (
      .clk(clk), .rst_n(rst_n), .clr_req(clr_req), .busy(busy[0]), .en(en), .we(we),
      .addr(addr), .din(din), .dout(dout[0]), .dout_vld(vld[0]));
   ram_sp_clr #(.DATA_W(8), .ADDR_W(10), .WR_MODE(1), .OUT_REG(0), .CLR_ON_RST(1), .CLR_VAL(8'h00)) u1 (
      .clk(clk), .rst_n(rst_n), .clr_req(clr_req), .busy(busy[1]), .en(en), .we(we),
      .addr(addr), .din(din), .dout(dout[1]), .dout_vld(vld[1]));
   ram_sp_clr #(.DATA_W(8), .ADDR_W(10), .WR_MODE(2), .OUT_REG(0), .CLR_ON_RST(1), .CLR_VAL(8'hFF)) u2 (
      .clk(clk), .rst_n(rst_n), .clr_req(clr_req), .busy(busy[2]), .en(en), .we(we),
      .addr(addr), .din(din), .dout(dout[2]), .dout_vld(vld[2]));
   ram_sp_clr #(.DATA_W(8), .ADDR_W(10), .WR_MODE(0), .OUT_REG(1), .CLR_ON_RST(1), .CLR_VAL(8'h00)) u3 (
      .clk(clk), .rst_n(rst_n), .clr_req(clr_req), .busy(busy[3]), .en(en), .we(we),
      .addr(addr), .din(din), .dout(dout[3]), .dout_vld(vld[3]));
   ram_sp_clr #(.DATA_W(8), .ADDR_W(10), .WR_MODE(0), .OUT_REG(0), .CLR_ON_RST(0), .CLR_VAL(8'h00)) u4 (
      .clk(clk), .rst_n(rst_n), .clr_req(clr_req), .busy(busy[4]), .en(en), .we(we),
      .addr(addr), .din(din), .dout(dout[4]), .dout_vld(vld[4]));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(negedge clk);
   endtask

   // One-cycle write issued at a negedge; returns at issue+1.
   task automatic wr(input logic [9:0] a, input logic [7:0] d);
      en = 1'b1; we = 1'b1; addr = a; din = d;
      tick;
      en = 1'b0; we = 1'b0;
   endtask

   // Read with checks at issue+1 (u0..u2, u3 not yet valid) and issue+2 (u3).
   task automatic rd_chk(input string tag, input logic [9:0] a, input logic [7:0] e, input logic [7:0] e2);
      en = 1'b1; we = 1'b0; addr = a;
      tick;
      en = 1'b0;
      chk({tag, "_d0"}, dout[0], e);  chk({tag, "_v0"}, vld[0], 1);
      chk({tag, "_d1"}, dout[1], e);  chk({tag, "_v1"}, vld[1], 1);
      chk({tag, "_d2"}, dout[2], e2); chk({tag, "_v2"}, vld[2], 1);
      chk({tag, "_v3e"}, vld[3], 0);
      tick;
      chk({tag, "_d3"}, dout[3], e);  chk({tag, "_v3"}, vld[3], 1);
      chk({tag, "_v0off"}, vld[0], 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      n_tests = 0; n_fail = 0;
      rst_n = 1'b0; clr_req = 1'b0; en = 1'b0; we = 1'b0; addr = '0; din = '0;
      tick; tick;

      // Reset state
      for (int i = 0; i < 5; i++) begin
         chk($sformatf("rst_dout%0d", i), dout[i], 0);
      end
      chk("rst_vld", vld, 0);
      chk("rst_busy", busy, 5'b01111);

      // Clear out of reset lasts DEPTH cycles
      rst_n = 1'b1;
      cnt = 0;
      do begin
         tick;
         cnt++;
      end while (busy[0] && cnt < 2000);
      chk("rst_busy_len", cnt, 1024);
      chk("rst_busy_all", busy, 0);

      rd_chk("rd0", 10'd0, 8'h00, 8'hFF);
      rd_chk("rd513", 10'd513, 8'h00, 8'hFF);
      rd_chk("rd1023", 10'd1023, 8'h00, 8'hFF);

      // Write then read 0x010
      wr(10'h010, 8'hA5);
      chk("w10_v0", vld[0], 0);
      chk("w10_d1", dout[1], 8'hA5); chk("w10_v1", vld[1], 1);
      chk("w10_d2", dout[2], 8'hFF); chk("w10_v2", vld[2], 1);
      tick;
      chk("w10_v3", vld[3], 0);
      rd_chk("rd10", 10'h010, 8'hA5, 8'hA5);

      // Read-during-write modes on 0x020
      wr(10'h020, 8'h3C);
      tick;
      wr(10'h020, 8'h77);
      chk("w20_v0", vld[0], 0);      chk("w20_d0", dout[0], 8'hA5);
      chk("w20_d1", dout[1], 8'h77); chk("w20_v1", vld[1], 1);
      chk("w20_d2", dout[2], 8'h3C); chk("w20_v2", vld[2], 1);
      tick;
      chk("w20_v3", vld[3], 0);      chk("w20_d3", dout[3], 8'hA5);
      rd_chk("rd20", 10'h020, 8'h77, 8'h77);

      // Back-to-back writes then reads of 0..15
      for (int i = 0; i < 16; i++) begin
         en = 1'b1; we = 1'b1; addr = 10'(i); din = 8'(8'h40 + i);
         tick;
      end
      for (int i = 0; i < 16; i++) begin
         en = 1'b1; we = 1'b0; addr = 10'(i);
         tick;
         chk($sformatf("seq_d0_%0d", i), dout[0], 8'(8'h40 + i));
         chk($sformatf("seq_v0_%0d", i), vld[0], 1);
         if (i == 0) begin
            chk("seq_v3_pre", vld[3], 0);
         end else begin
            chk($sformatf("seq_d3_%0d", i - 1), dout[3], 8'(8'h40 + i - 1));
            chk($sformatf("seq_v3_%0d", i - 1), vld[3], 1);
         end
      end
      en = 1'b0;
      tick;
      chk("seq_d3_15", dout[3], 8'h4F); chk("seq_v3_15", vld[3], 1);
      chk("seq_v0_end", vld[0], 0);
      tick;
      chk("seq_v3_end", vld[3], 0);

      // Clear request together with a read; write during busy; re-request mid-clear
      wr(10'h100, 8'h12);
      tick;
      clr_req = 1'b1; en = 1'b1; we = 1'b0; addr = 10'h100;
      tick;
      clr_req = 1'b0; en = 1'b0;
      cnt = 0;
      while (busy[0] && cnt < 2000) begin
         cnt++;
         if (cnt == 1) begin
            chk("clr_busy_rise", busy, 5'b11111);
            chk("clr_rd_d0", dout[0], 8'h12); chk("clr_rd_v0", vld[0], 1);
            chk("clr_rd_d2", dout[2], 8'h12); chk("clr_rd_v2", vld[2], 1);
            chk("clr_rd_v3e", vld[3], 0);
            en = 1'b1; we = 1'b1; addr = 10'h100; din = 8'h55;
         end
         if (cnt == 2) begin
            en = 1'b0; we = 1'b0;
            chk("busy_wr_v1", vld[1], 0);
            chk("clr_rd_d3", dout[3], 8'h12); chk("clr_rd_v3", vld[3], 1);
         end
         if (cnt == 100) clr_req = 1'b1;
         if (cnt == 101) clr_req = 1'b0;
         tick;
      end
      chk("clr_busy_len", cnt, 1024);
      chk("clr_busy_all", busy, 0);
      rd_chk("rd100_clr", 10'h100, 8'h00, 8'hFF);
      rd_chk("rd10_clr", 10'h010, 8'h00, 8'hFF);

      // Reset at clear address 300
      clr_req = 1'b1;
      tick;
      clr_req = 1'b0;
      lowcnt = 0;
      repeat (300) begin
         tick;
         if (!busy[0]) lowcnt++;
      end
      rst_n = 1'b0;
      tick;
      if (!busy[0]) lowcnt++;
      chk("mid_rst_busy_gap", lowcnt, 0);
      chk("mid_rst_busy_u4", busy[4], 0);
      chk("mid_rst_dout2", dout[2], 0);
      chk("mid_rst_vld", vld, 0);
      rst_n = 1'b1;
      cnt = 0;
      do begin
         tick;
         cnt++;
      end while (busy[0] && cnt < 2000);
      chk("mid_rst_busy_len", cnt, 1024);
      rd_chk("rd0_rst", 10'd0, 8'h00, 8'hFF);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
